// File: rtl/mq5_pkg.sv
// Shared definitions for the MQ-5 smoke alarm qualifier: state encoding and dwell width.
package mq5_pkg;

  localparam int DWELL_W = 16;
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  typedef enum logic [2:0] {
    ST_WARMUP  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PENDING = 3'd2,
    ST_ALARM   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_MUTED   = 3'd5
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle pulse every CLK_HZ/1000 clocks (1 ms).
module ms_tick_gen #(
  parameter int CLK_HZ = 12000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Count 0..DIV-1 and register the wrap as the tick so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == LAST);
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mq5_alarm_qualifier.sv
// Qualifies the raw MQ-5 digital output into a debounced alarm level with
// warm-up blanking, minimum on-time, release hysteresis and a timed mute.
module mq5_alarm_qualifier
  import mq5_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int WARMUP_MS  = 20000,
  parameter int ASSERT_MS  = 500,
  parameter int MIN_ON_MS  = 3000,
  parameter int RELEASE_MS = 2000,
  parameter int MUTE_MS    = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mq5_signal,
  input  logic       mute_req,
  output logic       alarm_on,
  output logic       alarm_rise,
  output logic       warming,
  output logic [2:0] state_dbg
);

  localparam logic [DWELL_W-1:0] WARMUP_N  = DWELL_W'(WARMUP_MS);
  localparam logic [DWELL_W-1:0] ASSERT_N  = DWELL_W'(ASSERT_MS);
  localparam logic [DWELL_W-1:0] MIN_ON_N  = DWELL_W'(MIN_ON_MS);
  localparam logic [DWELL_W-1:0] RELEASE_N = DWELL_W'(RELEASE_MS);
  localparam logic [DWELL_W-1:0] MUTE_N    = DWELL_W'(MUTE_MS);

  logic               tick;
  logic               sync1;
  logic               sync2;
  logic               smoke;
  logic [DWELL_W-1:0] dwell;
  logic               rise_set;
  state_t             state;
  state_t             next_state;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchronizer; resets to the sensor's idle (clear) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= mq5_signal;
      sync2 <= sync1;
    end
  end

  assign smoke = ~sync2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_WARMUP;
    else     state <= next_state;
  end

  // Single dwell timer: restarts on every state change, counts ms ticks, saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else if (next_state != state) begin
      dwell <= '0;
    end else if (tick && (dwell != DWELL_MAX)) begin
      dwell <= dwell + 1'b1;
    end
  end

  // Registered outputs aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_on   <= 1'b0;
      alarm_rise <= 1'b0;
    end else begin
      alarm_on   <= (next_state == ST_ALARM) || (next_state == ST_RELEASE);
      alarm_rise <= rise_set;
    end
  end

  // Next-state logic; only a fresh PENDING->ALARM qualification flags a rise
  always_comb begin
    next_state = state;
    rise_set   = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (dwell >= WARMUP_N) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (smoke) next_state = ST_PENDING;
      end
      ST_PENDING: begin
        if (!smoke) begin
          next_state = ST_IDLE;
        end else if (dwell >= ASSERT_N) begin
          next_state = ST_ALARM;
          rise_set   = 1'b1;
        end
      end
      ST_ALARM: begin
        if (mute_req)                          next_state = ST_MUTED;
        else if ((dwell >= MIN_ON_N) && !smoke) next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (smoke)                   next_state = ST_ALARM;
        else if (mute_req)           next_state = ST_MUTED;
        else if (dwell >= RELEASE_N) next_state = ST_IDLE;
      end
      ST_MUTED: begin
        if (dwell >= MUTE_N) next_state = smoke ? ST_ALARM : ST_IDLE;
      end
      default: next_state = ST_WARMUP;
    endcase
  end

  assign warming   = (state == ST_WARMUP);
  assign state_dbg = state;

endmodule

// File: tb/tb_mq5_alarm_qualifier.sv
// Directed self-checking bench for mq5_alarm_qualifier with a 4 kHz clock (4 clocks per ms).
module tb_mq5_alarm_qualifier;

  localparam logic [15:0] S_WARMUP  = 16'd0;
  localparam logic [15:0] S_IDLE    = 16'd1;
  localparam logic [15:0] S_PENDING = 16'd2;
  localparam logic [15:0] S_ALARM   = 16'd3;
  localparam logic [15:0] S_RELEASE = 16'd4;
  localparam logic [15:0] S_MUTED   = 16'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mq5_signal = 1'b0;
  logic       mute_req = 1'b0;
  logic       alarm_on;
  logic       alarm_rise;
  logic       warming;
  logic [2:0] state_dbg;

  int assertCount = 0;
  int failCount   = 0;
  int riseCount   = 0;
  int riseBase    = 0;

  mq5_alarm_qualifier #(
    .CLK_HZ    (4000),
    .WARMUP_MS (10),
    .ASSERT_MS (5),
    .MIN_ON_MS (20),
    .RELEASE_MS(8),
    .MUTE_MS   (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mq5_signal(mq5_signal),
    .mute_req  (mute_req),
    .alarm_on  (alarm_on),
    .alarm_rise(alarm_rise),
    .warming   (warming),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Tally alarm_rise pulses seen at each clock edge
  always @(posedge clk) if (alarm_rise === 1'b1) riseCount++;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic smokeLine, input logic mutePulse);
    mq5_signal = smokeLine;
    mute_req   = mutePulse;
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(3);
    checkOutput("rst_state", 16'(state_dbg), S_WARMUP);
    checkOutput("rst_alarm_on", 16'(alarm_on), 16'd0);
    checkOutput("rst_alarm_rise", 16'(alarm_rise), 16'd0);
    checkOutput("rst_warming", 16'(warming), 16'd1);
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    // Smoke present from power-up: blanked for 10 ms, then qualified after 5 ms
    applyStimulus(1'b0, 1'b0);
    doReset();
    riseBase = riseCount;
    step(41);
    checkOutput("t1_warm_state", 16'(state_dbg), S_WARMUP);
    checkOutput("t1_warm_flag", 16'(warming), 16'd1);
    checkOutput("t1_warm_alarm", 16'(alarm_on), 16'd0);
    step(1);
    checkOutput("t1_idle", 16'(state_dbg), S_IDLE);
    checkOutput("t1_warm_drop", 16'(warming), 16'd0);
    step(1);
    checkOutput("t1_pending", 16'(state_dbg), S_PENDING);
    step(18);
    checkOutput("t1_pend_hold", 16'(state_dbg), S_PENDING);
    checkOutput("t1_pend_alarm", 16'(alarm_on), 16'd0);
    step(1);
    checkOutput("t1_alarm", 16'(state_dbg), S_ALARM);
    checkOutput("t1_alarm_on", 16'(alarm_on), 16'd1);
    checkOutput("t1_rise", 16'(alarm_rise), 16'd1);
    step(1);
    checkOutput("t1_rise_end", 16'(alarm_rise), 16'd0);
    checkOutput("t1_rise_count", 16'(riseCount - riseBase), 16'd1);

    // Short 4 ms burst of smoke must not qualify
    applyStimulus(1'b1, 1'b0);
    doReset();
    step(42);
    checkOutput("t2_idle", 16'(state_dbg), S_IDLE);
    riseBase = riseCount;
    applyStimulus(1'b0, 1'b0);
    step(2);
    checkOutput("t2_sync_lat", 16'(state_dbg), S_IDLE);
    step(1);
    checkOutput("t2_pending", 16'(state_dbg), S_PENDING);
    step(13);
    checkOutput("t2_pend_hold", 16'(state_dbg), S_PENDING);
    applyStimulus(1'b1, 1'b0);
    step(3);
    checkOutput("t2_back_idle", 16'(state_dbg), S_IDLE);
    checkOutput("t2_alarm_off", 16'(alarm_on), 16'd0);
    checkOutput("t2_no_rise", 16'(riseCount - riseBase), 16'd0);

    // 6 ms smoke: 20 ms minimum on-time then 8 ms release
    riseBase = riseCount;
    applyStimulus(1'b0, 1'b0);
    step(3);
    checkOutput("t3_pending", 16'(state_dbg), S_PENDING);
    step(18);
    checkOutput("t3_alarm", 16'(state_dbg), S_ALARM);
    checkOutput("t3_rise", 16'(alarm_rise), 16'd1);
    step(3);
    applyStimulus(1'b1, 1'b0);
    step(76);
    checkOutput("t3_min_on", 16'(state_dbg), S_ALARM);
    checkOutput("t3_min_on_lvl", 16'(alarm_on), 16'd1);
    step(1);
    checkOutput("t3_release", 16'(state_dbg), S_RELEASE);
    checkOutput("t3_release_lvl", 16'(alarm_on), 16'd1);
    step(31);
    checkOutput("t3_rel_hold", 16'(alarm_on), 16'd1);
    step(1);
    checkOutput("t3_idle", 16'(state_dbg), S_IDLE);
    checkOutput("t3_alarm_off", 16'(alarm_on), 16'd0);
    checkOutput("t3_rise_count", 16'(riseCount - riseBase), 16'd1);

    // Smoke returns 5 ms into release: straight back to ALARM, no new rise
    riseBase = riseCount;
    applyStimulus(1'b0, 1'b0);
    step(3);
    checkOutput("t4_pending", 16'(state_dbg), S_PENDING);
    step(21);
    checkOutput("t4_alarm", 16'(state_dbg), S_ALARM);
    step(4);
    applyStimulus(1'b1, 1'b0);
    step(75);
    checkOutput("t4_min_on", 16'(state_dbg), S_ALARM);
    step(1);
    checkOutput("t4_release", 16'(state_dbg), S_RELEASE);
    step(19);
    applyStimulus(1'b0, 1'b0);
    step(2);
    checkOutput("t4_rel_lat", 16'(state_dbg), S_RELEASE);
    checkOutput("t4_rel_lvl", 16'(alarm_on), 16'd1);
    step(1);
    checkOutput("t4_realarm", 16'(state_dbg), S_ALARM);
    checkOutput("t4_realarm_lvl", 16'(alarm_on), 16'd1);
    checkOutput("t4_realarm_rise", 16'(alarm_rise), 16'd0);
    checkOutput("t4_rise_count", 16'(riseCount - riseBase), 16'd1);

    // Mute while smoke held: silent 15 ms (repeat mute ignored), then back on quietly
    riseBase = riseCount;
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_muted", 16'(state_dbg), S_MUTED);
    checkOutput("t5_muted_lvl", 16'(alarm_on), 16'd0);
    step(9);
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_remute", 16'(state_dbg), S_MUTED);
    step(50);
    checkOutput("t5_mute_hold", 16'(state_dbg), S_MUTED);
    checkOutput("t5_mute_hold_lvl", 16'(alarm_on), 16'd0);
    step(1);
    checkOutput("t5_unmute", 16'(state_dbg), S_ALARM);
    checkOutput("t5_unmute_lvl", 16'(alarm_on), 16'd1);
    checkOutput("t5_unmute_rise", 16'(alarm_rise), 16'd0);
    checkOutput("t5_rise_count", 16'(riseCount - riseBase), 16'd0);

    // Reset during ALARM: immediate drop and full warm-up; mute ignored in PENDING
    rst = 1'b1;
    step(1);
    checkOutput("t6_abort_lvl", 16'(alarm_on), 16'd0);
    checkOutput("t6_abort_warm", 16'(warming), 16'd1);
    checkOutput("t6_abort_state", 16'(state_dbg), S_WARMUP);
    rst = 1'b0;
    step(41);
    checkOutput("t6_warm_state", 16'(state_dbg), S_WARMUP);
    checkOutput("t6_warm_lvl", 16'(alarm_on), 16'd0);
    step(1);
    checkOutput("t6_idle", 16'(state_dbg), S_IDLE);
    step(8);
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_pend_mute", 16'(state_dbg), S_PENDING);
    step(11);
    checkOutput("t6_alarm", 16'(state_dbg), S_ALARM);
    checkOutput("t6_rise", 16'(alarm_rise), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
